// File: rtl/xadc_axil_sample_slave.sv
// AXI4-Lite register slave for the XADC capture path.
// Holds CTRL/STAT/SMP/CNT and captures end-of-conversion samples.
// Write and read channels run independent two-state FSMs. All handshake
// outputs are registered.
module xadc_axil_sample_slave #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int SMP_W  = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  // sample source
  input  logic                  smp_valid,
  input  logic [SMP_W-1:0]      smp_data,
  // write address
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  // write data
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  // write response
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // read address
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // read data
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_SMP  = 2'd2;
  localparam logic [1:0] A_CNT  = 2'd3;

  // Any address bit above the 16-byte window selects nothing. Shifting
  // rather than slicing keeps this legal when ADDR_W is exactly 4.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] hi;
    hi = a >> 4;
    return |hi;
  endfunction

  // ---------------------------------------------------------------
  // register file state
  // ---------------------------------------------------------------
  logic              ctrl_en;
  logic              st_new;
  logic              st_ovr;
  logic [SMP_W-1:0]  smp_q;
  logic [DATA_W-1:0] cnt_q;

  // ---------------------------------------------------------------
  // write channel state
  // ---------------------------------------------------------------
  wstate_t     w_state;
  logic        aw_held;
  logic        w_held;
  logic [1:0]  aw_sel_q;
  logic        aw_bad_q;
  logic [1:0]  wdata_q;
  logic        wstrb0_q;

  // write commits in the idle cycle where both beats are already held
  logic       wr_fire;
  logic       wr_ok;
  logic       wr_ctrl;
  logic       wr_stat;
  logic       clr;

  assign wr_fire = (w_state == W_IDLE) && aw_held && w_held;
  assign wr_ok   = wr_fire && !aw_bad_q && wstrb0_q;
  assign wr_ctrl = wr_ok && (aw_sel_q == A_CTRL);
  assign wr_stat = wr_ok && (aw_sel_q == A_STAT);
  assign clr     = wr_ctrl && wdata_q[1];

  // ---------------------------------------------------------------
  // read channel state
  // ---------------------------------------------------------------
  rstate_t r_state;
  logic    rd_fire;
  logic    rd_bad;
  logic    smp_rd_clr;
  logic [DATA_W-1:0] rd_val;

  assign rd_fire    = s_arready && s_arvalid;
  assign rd_bad     = addr_bad(s_araddr);
  assign smp_rd_clr = rd_fire && !rd_bad && (s_araddr[3:2] == A_SMP);

  // capture qualifies on the enable as it stands this cycle
  logic cap;
  assign cap = smp_valid && ctrl_en;

  // low address bits and upper data/strobe bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{s_araddr[1:0], s_awaddr[1:0],
                         s_wdata[DATA_W-1:2], s_wstrb[DATA_W/8-1:1]};

  // Read mux: clear bit always reads back 0, unused bits are 0.
  always_comb begin
    rd_val = '0;
    unique case (s_araddr[3:2])
      A_CTRL: rd_val[0]       = ctrl_en;
      A_STAT: rd_val[1:0]     = {st_ovr, st_new};
      A_SMP:  rd_val[SMP_W-1:0] = smp_q;
      A_CNT:  rd_val          = cnt_q;
      default: rd_val         = '0;
    endcase
  end

  // Write FSM: collect AW and W in any order, commit, then hold B until taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_sel_q  <= '0;
      aw_bad_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb0_q  <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= aw_bad_q ? RESP_SLVERR : RESP_OKAY;
            w_state   <= W_RESP;
          end else begin
            if (s_awready && s_awvalid) begin
              aw_sel_q  <= s_awaddr[3:2];
              aw_bad_q  <= addr_bad(s_awaddr);
              aw_held   <= 1'b1;
              s_awready <= 1'b0;
            end else if (!aw_held) begin
              s_awready <= 1'b1;
            end
            if (s_wready && s_wvalid) begin
              wdata_q  <= s_wdata[1:0];
              wstrb0_q <= s_wstrb[0];
              w_held   <= 1'b1;
              s_wready <= 1'b0;
            end else if (!w_held) begin
              s_wready <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: register data one cycle after AR, hold R until taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (rd_fire) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            s_rdata   <= rd_bad ? '0 : rd_val;
            s_rresp   <= rd_bad ? RESP_SLVERR : RESP_OKAY;
            r_state   <= R_DATA;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Register file: clear beats capture; capture beats SMP read-clear;
  // an overrun from a capture beats a same-cycle W1C.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_en <= 1'b0;
      st_new  <= 1'b0;
      st_ovr  <= 1'b0;
      smp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (wr_ctrl) ctrl_en <= wdata_q[0];
      if (clr) begin
        smp_q  <= '0;
        cnt_q  <= '0;
        st_new <= 1'b0;
        st_ovr <= 1'b0;
      end else begin
        if (cap) begin
          smp_q  <= smp_data;
          cnt_q  <= cnt_q + 1'b1;
          st_new <= 1'b1;
        end else if (smp_rd_clr) begin
          st_new <= 1'b0;
        end
        if (cap && st_new)             st_ovr <= 1'b1;
        else if (wr_stat && wdata_q[1]) st_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xadc_axil_sample_slave.sv
// Bench for xadc_axil_sample_slave: directed scenarios plus a random mix,
// all checked against a register-level model of the sample slave.
module tb_xadc_axil_sample_slave;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          smp_valid = 1'b0;
  logic [SW-1:0] smp_data = '0;
  logic [AW-1:0] s_awaddr = '0;
  logic          s_awvalid = 1'b0;
  logic          s_awready;
  logic [DW-1:0] s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready = 1'b0;
  logic [AW-1:0] s_araddr = '0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready = 1'b0;

  xadc_axil_sample_slave #(.ADDR_W(AW), .DATA_W(DW), .SMP_W(SW)) dut (
    .clk(clk), .rstn(rstn), .smp_valid(smp_valid), .smp_data(smp_data),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  bit          m_en, m_new, m_ovr;
  logic [SW-1:0] m_smp;
  logic [31:0] m_cnt;

  function automatic void m_reset();
    m_en = 0; m_new = 0; m_ovr = 0; m_smp = '0; m_cnt = '0;
  endfunction

  function automatic void m_capture(input logic [SW-1:0] d);
    if (m_en) begin
      if (m_new) m_ovr = 1;
      m_new = 1;
      m_smp = d;
      m_cnt = m_cnt + 1;
    end
  endfunction

  function automatic logic [31:0] m_reg(input logic [AW-1:0] a);
    if (a >= 16) return 32'h0;
    case (a / 4)
      0: return {31'h0, m_en};
      1: return {30'h0, m_ovr, m_new};
      2: return {20'h0, m_smp};
      default: return m_cnt;
    endcase
  endfunction

  function automatic logic [1:0] m_resp(input logic [AW-1:0] a);
    return (a >= 16) ? 2'b10 : 2'b00;
  endfunction

  function automatic void m_write(input logic [AW-1:0] a, input logic [31:0] d,
                                  input logic [3:0] s);
    if (a >= 16 || !s[0]) return;
    if (a / 4 == 0) begin
      m_en = d[0];
      if (d[1]) begin m_smp = '0; m_cnt = '0; m_new = 0; m_ovr = 0; end
    end else if (a / 4 == 1) begin
      if (d[1]) m_ovr = 0;
    end
  endfunction

  // expected read value, then the side effects the read has on the model
  function automatic logic [31:0] m_read(input logic [AW-1:0] a, input bit cap,
                                         input logic [SW-1:0] cd);
    logic [31:0] v;
    v = m_reg(a);
    if (cap && m_en) m_capture(cd);
    else if (a < 16 && a / 4 == 2) m_new = 0;
    return v;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic pulse(input logic [SW-1:0] d);
    @(negedge clk); smp_valid = 1; smp_data = d;
    @(negedge clk); smp_valid = 0;
    m_capture(d);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int hold, input bit cap,
                          input logic [SW-1:0] cd, output logic [31:0] d,
                          output logic [1:0] r);
    int n;
    d = 'x; r = 'x;
    @(negedge clk); s_araddr = a; s_arvalid = 1;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge clk); n++; end
    if (!s_arready) begin
      total++; bad++; s_arvalid = 0;
      $display("FAIL rd_arready_timeout addr=%h", a);
      return;
    end
    if (cap) begin smp_valid = 1; smp_data = cd; end
    @(negedge clk); s_arvalid = 0; smp_valid = 0;
    total++;
    if (s_rvalid !== 1'b1) begin
      bad++; $display("FAIL rd_latency got rvalid=%b want 1", s_rvalid);
      n = 0;
      while (!s_rvalid && n < 50) begin @(negedge clk); n++; end
    end
    d = s_rdata; r = s_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (s_rvalid !== 1'b1 || s_rdata !== d || s_arready !== 1'b0) begin
        bad++;
        $display("FAIL rd_hold got rvalid=%b rdata=%h arready=%b want 1 %h 0",
                 s_rvalid, s_rdata, s_arready, d);
      end
    end
    s_rready = 1;
    @(negedge clk); s_rready = 0;
    total++;
    if (s_rvalid !== 1'b0) begin bad++; $display("FAIL rd_done got rvalid=%b want 0", s_rvalid); end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly, input int w_dly,
                           input int hold, output logic [1:0] r);
    int t, n;
    bit aw_done, w_done, aw_go, w_go;
    t = 0; aw_done = 0; w_done = 0; aw_go = 0; w_go = 0; r = 'x;
    while (!(aw_done && w_done) && t < 100) begin
      @(negedge clk);
      if (aw_go) begin s_awvalid = 0; aw_done = 1; end
      if (w_go)  begin s_wvalid = 0;  w_done = 1;  end
      if (!aw_done && t >= aw_dly) begin s_awaddr = a; s_awvalid = 1; end
      if (!w_done && t >= w_dly) begin s_wdata = d; s_wstrb = s; s_wvalid = 1; end
      aw_go = s_awvalid && s_awready;
      w_go  = s_wvalid && s_wready;
      t++;
    end
    if (!(aw_done && w_done)) begin
      total++; bad++; s_awvalid = 0; s_wvalid = 0;
      $display("FAIL wr_accept_timeout aw=%b w=%b", aw_done, w_done);
      return;
    end
    n = 0;
    while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
    total++;
    if (!s_bvalid) begin bad++; $display("FAIL wr_bvalid_timeout"); return; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (s_bvalid !== 1'b1 || s_awready !== 1'b0 || s_wready !== 1'b0) begin
        bad++;
        $display("FAIL wr_hold got bvalid=%b awready=%b wready=%b want 1 0 0",
                 s_bvalid, s_awready, s_wready);
      end
    end
    r = s_bresp;
    s_bready = 1;
    @(negedge clk); s_bready = 0;
    total++;
    if (s_bvalid !== 1'b0) begin bad++; $display("FAIL wr_done got bvalid=%b want 0", s_bvalid); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    #12;
    total++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 5'b0 ||
        s_rdata !== 32'h0 || s_bresp !== 2'b0 || s_rresp !== 2'b0) begin
      bad++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b rdata=%h want all 0",
               s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata);
    end
    #10 rstn = 1;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(i * 4), 0, 0, '0, d, r);
      total++;
      if (d !== 32'h0 || r !== 2'b00) begin
        bad++; $display("FAIL reset_reg%0d got %h/%b want 0/00", i, d, r);
      end
    end
  endtask

  task automatic test_write_order();
    logic [31:0] d; logic [1:0] r;
    axi_write(6'h0, 32'h1, 4'hF, 0, 3, 5, r);   // AW leads W by 3
    m_write(6'h0, 32'h1, 4'hF);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL wr_aw_first_bresp got %b want 00", r); end
    axi_read(6'h0, 0, 0, '0, d, r);
    total++; if (d !== m_reg(6'h0)) begin bad++; $display("FAIL wr_aw_first_ctrl got %h want %h", d, m_reg(6'h0)); end
    axi_write(6'h0, 32'h0, 4'hF, 0, 0, 0, r);   // same cycle, disable
    m_write(6'h0, 32'h0, 4'hF);
    axi_write(6'h0, 32'h1, 4'hF, 3, 0, 2, r);   // W leads AW by 3
    m_write(6'h0, 32'h1, 4'hF);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL wr_w_first_bresp got %b want 00", r); end
    axi_read(6'h0, 0, 0, '0, d, r);
    total++; if (d !== m_reg(6'h0)) begin bad++; $display("FAIL wr_w_first_ctrl got %h want %h", d, m_reg(6'h0)); end
    axi_write(6'h0, 32'h0, 4'hE, 0, 0, 0, r);   // strobe lane 0 off: ignored
    m_write(6'h0, 32'h0, 4'hE);
    axi_read(6'h0, 0, 0, '0, d, r);
    total++; if (d !== 32'h1 || r !== 2'b00) begin bad++; $display("FAIL wr_nostrb_ctrl got %h/%b want 1/00", d, r); end
  endtask

  task automatic test_capture();
    logic [31:0] d; logic [1:0] r;
    pulse(12'hABC);
    axi_read(6'h4, 0, 0, '0, d, r);  void'(m_read(6'h4, 0, '0));
    total++; if (d !== 32'h1) begin bad++; $display("FAIL cap_stat got %h want 1", d); end
    axi_read(6'h8, 0, 0, '0, d, r);  void'(m_read(6'h8, 0, '0));
    total++; if (d !== 32'hABC) begin bad++; $display("FAIL cap_smp got %h want abc", d); end
    axi_read(6'hC, 0, 0, '0, d, r);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL cap_cnt got %h want 1", d); end
    axi_read(6'h4, 0, 0, '0, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cap_stat_cleared got %h want 0", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d; logic [1:0] r;
    pulse(12'h123); pulse(12'h456);
    axi_read(6'h4, 0, 0, '0, d, r);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL ovr_stat got %h want 3", d); end
    axi_write(6'h4, 32'h2, 4'h1, 0, 0, 0, r);
    m_write(6'h4, 32'h2, 4'h1);
    axi_read(6'h4, 0, 0, '0, d, r);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL ovr_w1c got %h want 1", d); end
    axi_read(6'h8, 0, 0, '0, d, r);  void'(m_read(6'h8, 0, '0));
    total++; if (d !== 32'h456) begin bad++; $display("FAIL ovr_smp got %h want 456", d); end
  endtask

  task automatic test_read_capture();
    logic [31:0] d, e; logic [1:0] r;
    e = m_read(6'h8, 1, 12'h7FF);
    axi_read(6'h8, 0, 1, 12'h7FF, d, r);
    total++; if (d !== e) begin bad++; $display("FAIL rdcap_old got %h want %h", d, e); end
    axi_read(6'h4, 0, 0, '0, d, r);  e = m_read(6'h4, 0, '0);
    total++; if (d !== e || d[0] !== 1'b1) begin bad++; $display("FAIL rdcap_new got %h want %h", d, e); end
    axi_read(6'h8, 0, 0, '0, d, r);  e = m_read(6'h8, 0, '0);
    total++; if (d !== 32'h7FF) begin bad++; $display("FAIL rdcap_smp got %h want 7ff", d); end
  endtask

  task automatic test_clear();
    logic [31:0] d; logic [1:0] r;
    pulse(12'h0F0);
    axi_write(6'h0, 32'h3, 4'h1, 0, 0, 0, r);
    m_write(6'h0, 32'h3, 4'h1);
    axi_read(6'hC, 4, 0, '0, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL clr_cnt got %h want 0", d); end
    axi_read(6'h4, 4, 0, '0, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL clr_stat got %h want 0", d); end
    axi_read(6'h0, 4, 0, '0, d, r);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL clr_ctrl got %h want 1", d); end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r;
    axi_read(6'h10, 0, 0, '0, d, r);
    total++; if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL slverr_rd got %h/%b want 0/10", d, r); end
    axi_write(6'h20, 32'h0, 4'hF, 0, 0, 0, r);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL slverr_wr got %b want 10", r); end
    axi_read(6'h0, 0, 0, '0, d, r);
    total++; if (d !== m_reg(6'h0)) begin bad++; $display("FAIL slverr_noeffect got %h want %h", d, m_reg(6'h0)); end
  endtask

  task automatic test_random();
    logic [31:0] d, e, wd; logic [1:0] r, er;
    logic [AW-1:0] a;
    logic [SW-1:0] cd;
    bit cap;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: pulse(SW'($urandom));
        1: begin
          a   = AW'($urandom_range(0, 15));
          if ($urandom_range(0, 9) == 0) a = AW'($urandom_range(16, 63));
          cap = ($urandom_range(0, 3) == 0);
          cd  = SW'($urandom);
          er  = m_resp(a);
          e   = m_read(a, cap, cd);
          axi_read(a, $urandom_range(0, 2), cap, cd, d, r);
          total++;
          if (d !== e || r !== er) begin
            bad++; $display("FAIL rand_rd addr=%h got %h/%b want %h/%b", a, d, r, e, er);
          end
        end
        default: begin
          a  = AW'($urandom_range(0, 1) * 4);
          wd = {30'h0, ($urandom_range(0, 4) == 0), 1'b1};
          if ($urandom_range(0, 5) == 0) wd[0] = 1'b0;
          if (a != 0) wd = 32'($urandom);
          axi_write(a, wd, 4'($urandom_range(0, 15)) | 4'h1, $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 1), r);
          m_write(a, wd, 4'h1);
          total++;
          if (r !== 2'b00) begin bad++; $display("FAIL rand_wr addr=%h got %b want 00", a, r); end
        end
      endcase
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic [1:0] r;
    int n;
    @(negedge clk); s_araddr = 6'hC; s_arvalid = 1;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); s_arvalid = 0;
    #2 rstn = 0;
    #1;
    total++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b0 || s_rdata !== 32'h0) begin
      bad++; $display("FAIL abort_outputs got rvalid=%b arready=%b rdata=%h want 0 0 0",
                      s_rvalid, s_arready, s_rdata);
    end
    @(negedge clk); rstn = 1;
    m_reset();
    axi_read(6'hC, 0, 0, '0, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_cnt got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_write_order();
    test_capture();
    test_overrun();
    test_read_capture();
    test_clear();
    test_slverr();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
